// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//   Bit-serial adder: adds two WIDTH-bit operands LSB-first, one bit per clock,
//   using one full-adder cell (two half adders + OR) and a carry flop.
//   Operands enter over a valid/ready handshake; {cout,sum} leaves over a
//   valid/ready handshake and is held stable until accepted.
//
//   Optional macro SERIAL_ADDER_OVF_EN adds output ovf (two's-complement
//   signed overflow of the final bit).
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   in_valid   operands a, b, cin valid
//   in_ready   block can accept operands (0 while rst=1)
//   a, b       WIDTH-bit operands
//   cin        carry-in to bit 0
//   out_valid  sum/cout valid
//   out_ready  consumer accepts result
//   sum        registered WIDTH-bit sum
//   cout       registered carry-out of bit WIDTH-1
//   ovf        (SERIAL_ADDER_OVF_EN only) signed overflow flag
// -----------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_sum_sr;
    logic             r_carry;
    logic             r_cout;
    logic [CW-1:0]    r_cnt;

    logic w_accept;
    logic w_release;
    logic w_last;

    // Full-adder cell: two half adders, carries ORed
    logic w_s0, w_c0, w_s, w_c1, w_c;

    half_adder u_ha0 (
        .x (r_a_sr[0]),
        .y (r_b_sr[0]),
        .s (w_s0),
        .c (w_c0)
    );

    half_adder u_ha1 (
        .x (w_s0),
        .y (r_carry),
        .s (w_s),
        .c (w_c1)
    );

    assign w_c = w_c0 | w_c1;

    assign in_ready  = (r_state == IDLE) && !rst;
    assign out_valid = (r_state == DONE);
    assign sum       = r_sum_sr;
    assign cout      = r_cout;

    assign w_accept  = in_valid & in_ready;
    assign w_release = out_valid & out_ready;
    assign w_last    = (r_cnt == LAST);

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept)  w_state_nxt = SHIFT;
            SHIFT:   if (w_last)    w_state_nxt = DONE;
            DONE:    if (w_release) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath: operand/sum shift registers, carry flop, bit counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_sum_sr <= '0;
            r_carry  <= 1'b0;
            r_cout   <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a_sr  <= a;
                        r_b_sr  <= b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                    end
                end
                SHIFT: begin
                    r_a_sr   <= r_a_sr >> 1;
                    r_b_sr   <= r_b_sr >> 1;
                    // LSB is produced first, so after WIDTH shifts it lands in bit 0
                    r_sum_sr <= {w_s, r_sum_sr[WIDTH-1:1]};
                    r_carry  <= w_c;
                    r_cnt    <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_cout <= w_c;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic r_ovf;

    // On the last bit r_carry is the carry into bit WIDTH-1, w_c the carry out
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (r_state == SHIFT && w_last) begin
            r_ovf <= r_carry ^ w_c;
        end
    end

    assign ovf = r_ovf;
`endif

endmodule

// -----------------------------------------------------------------------------
// half_adder
//   One-bit half adder used to build the serial adder's full-adder cell.
// Ports:
//   x, y  input bits
//   s     sum bit (x ^ y)
//   c     carry bit (x & y)
// -----------------------------------------------------------------------------
module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);

    assign s = x ^ y;
    assign c = x & y;

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//   Self-checking bench for serial_adder (WIDTH=8). Expected {ovf,cout,sum}
//   entries are queued when operands are accepted and popped when a result
//   handshake is seen. Build with SERIAL_ADDER_OVF_EN to also check ovf.
// -----------------------------------------------------------------------------
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int rise_cyc = 0;
    int n_done   = 0;
    logic prev_ov = 1'b0;

    // {ovf, cout, sum}
    logic [W+1:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Result monitor: a handshake seen at the negedge completes on the next posedge
    always @(negedge clk) begin
        logic [W+1:0] e;
        if (out_valid && !prev_ov) rise_cyc = cyc;
        prev_ov = out_valid;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check("sum",  32'(sum),  32'(e[W-1:0]));
                check("cout", 32'(cout), 32'(e[W]));
`ifdef SERIAL_ADDER_OVF_EN
                check("ovf",  32'(ovf),  32'(e[W+1]));
`endif
            end
            n_done++;
        end
    end

    // Drive one operand set and wait for it to be accepted; returns accept cycle
    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                        input bit push, input bit keep, output int acc);
        int n;
        logic [W:0]   full;
        logic         e_ovf;
        @(negedge clk);
        in_valid = 1'b1;
        a = ta;
        b = tb_v;
        cin = tc;
        n = 0;
        #1;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 100) check("accept_timeout", 32'd0, 32'd1);
        full  = {1'b0, ta} + {1'b0, tb_v} + {{W{1'b0}}, tc};
        e_ovf = (ta[W-1] == tb_v[W-1]) && (full[W-1] != ta[W-1]);
        if (push) exp_q.push_back({e_ovf, full});
        @(posedge clk);
        #1;
        acc = cyc;
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (n_done < target && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("result_timeout", 32'(n_done), 32'(target));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc;
        int acc_b2b[3];
        logic [W-1:0] va[3];
        logic [W-1:0] vb[3];
        logic         vc[3];

        rst = 1'b1;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum",       32'(sum),       32'd0);
        check("rst_cout",      32'(cout),      32'd0);
        rst = 1'b0;
        #1;
        check("idle_in_ready", 32'(in_ready), 32'd1);

        // Basic add with latency check
        send(8'h5A, 8'h3C, 1'b0, 1, 0, acc);
        wait_done(1);
        check("latency", 32'(rise_cyc - acc), 32'(W));
        @(negedge clk);
        check("in_ready_after", 32'(in_ready), 32'd1);

        // Carry out of MSB
        send(8'hFF, 8'h01, 1'b0, 1, 0, acc);
        wait_done(2);
        send(8'hFF, 8'hFF, 1'b1, 1, 0, acc);
        wait_done(3);

        // Backpressure: hold result, refuse new operands
        out_ready = 1'b0;
        send(8'h12, 8'h34, 1'b0, 1, 0, acc);
        begin
            int n = 0;
            while (!out_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
            check("bp_valid", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b1;
        a = 8'h01;
        b = 8'h01;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_sum",   32'(sum),       32'h46);
            check("bp_in_ready",   32'(in_ready),  32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_done(4);
        @(negedge clk);
        check("bp_released", 32'(in_ready), 32'd1);

        // Reset in the middle of SHIFT discards the partial result
        send(8'hAA, 8'h55, 1'b0, 0, 0, acc);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_sum",       32'(sum),       32'd0);
        check("mid_rst_cout",      32'(cout),      32'd0);
        rst = 1'b0;
        #1;
        check("mid_rst_in_ready1", 32'(in_ready), 32'd1);
        repeat (W + 2) @(negedge clk);
        check("mid_rst_no_result", 32'(out_valid), 32'd0);
        send(8'h01, 8'h01, 1'b0, 1, 0, acc);
        wait_done(5);

        // Back-to-back with in_valid held high
        va[0] = 8'hA5; vb[0] = 8'h5A; vc[0] = 1'b1;
        va[1] = 8'h80; vb[1] = 8'h7F; vc[1] = 1'b0;
        va[2] = 8'h13; vb[2] = 8'hF0; vc[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send(va[i], vb[i], vc[i], 1, (i < 2), acc_b2b[i]);
        end
        check("b2b_spacing0", 32'(acc_b2b[1] - acc_b2b[0]), 32'(W + 2));
        check("b2b_spacing1", 32'(acc_b2b[2] - acc_b2b[1]), 32'(W + 2));
        wait_done(8);

        // Signed-overflow patterns (ovf compared only when the feature is built)
        send(8'h7F, 8'h01, 1'b0, 1, 0, acc);
        wait_done(9);
        send(8'h80, 8'h80, 1'b0, 1, 0, acc);
        wait_done(10);
        send(8'h40, 8'h20, 1'b0, 1, 0, acc);
        wait_done(11);

        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
